rfsm: RTL and testbench
=======================

RFSM -- requirements
Module: rfsm

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the number of data bits per frame (legal range 1..32).
REQ-002 clk  input  1  rising-edge system clock; one serial bit period equals one clk cycle.
REQ-003 rst_n  input  1  asynchronous, active-high reset (asserted when 1); the port name is kept for bus compatibility.
REQ-004 d_ready  input  1  serial receive line; idle high, start bit low, stop bit high.
REQ-005 p_error  input  1  parity-mismatch flag from the external parity checker, valid during the PARITY state.
REQ-006 sel  output  1  data-shift select; high while data bits are on the line.
REQ-007 d_load  output  1  single-cycle pulse telling the datapath to load the received word.

Function
REQ-008 The FSM SHALL have states IDLE, DATA, PARITY, STOP, LOAD and ERR, held in a registered state variable.
REQ-009 sel SHALL be a Moore decode, equal to 1 only in DATA; d_load SHALL be a Moore decode, equal to 1 only in LOAD; both outputs SHALL be glitch-free.
REQ-010 IDLE: at a clock edge with d_ready=0, the FSM SHALL go to DATA and clear the bit counter; otherwise it SHALL stay in IDLE.
REQ-011 DATA: the FSM SHALL remain in DATA for exactly WIDTH cycles, counted by a counter of $clog2(WIDTH+1) bits, and SHALL then go to PARITY (or to STOP when parity is compiled out).
REQ-012 PARITY: the FSM SHALL last one cycle; at its closing edge it SHALL latch p_error into perr_q and go to STOP.
REQ-013 STOP: the FSM SHALL last one cycle; at its closing edge it SHALL do the following:
- go to LOAD if d_ready=1 and perr_q=0;
- go to IDLE if d_ready=1 and perr_q=1 (parity error, word discarded);
- go to ERR if d_ready=0 (framing error).
REQ-014 LOAD: the FSM SHALL last one cycle; at its closing edge it SHALL go to DATA if d_ready=0 (back-to-back start bit), otherwise to IDLE.
REQ-015 ERR: the FSM SHALL stay in ERR while d_ready=0 and go to IDLE at the first edge with d_ready=1; d_ready low in ERR SHALL never start a frame.
REQ-016 p_error SHALL be ignored in every state except PARITY.
REQ-017 perr_q SHALL be cleared on entry to DATA.
REQ-018 Any unreachable state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-019 While rst_n=1, the FSM SHALL immediately force state=IDLE, counter=0, perr_q=0, sel=0 and d_load=0, without waiting for a clock edge.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no d_load pulse; after release, the FSM SHALL wait for a new d_ready=0 sample in IDLE.

Configuration
REQ-021 With macro RFSM_PARITY_EN defined, the PARITY state SHALL exist and a parity error SHALL suppress d_load.
REQ-022 Without RFSM_PARITY_EN, DATA SHALL go directly to STOP, perr_q SHALL be tied to 0, and p_error SHALL be unused.

Verification (WIDTH=8, RFSM_PARITY_EN defined, edge 0 = first edge sampling d_ready=0)
REQ-023 Reset: drive rst_n=1 mid-cycle -> sel=0 and d_load=0 before the next edge; the FSM stays in IDLE with d_ready=1.
REQ-024 Good frame: d_ready=0, then 8 data bits, p_error=0 during PARITY, d_ready=1 at STOP:
- sel=1 for exactly the cycles after edges 0..7;
- d_load=1 only between edges 10 and 11.
REQ-025 Parity error: same frame with p_error=1 during PARITY -> d_load stays 0 and the FSM is in IDLE after edge 10.
REQ-026 Framing error: d_ready=0 at STOP -> ERR after edge 10 with sel=0 and d_load=0; the FSM stays in ERR while d_ready=0 and goes to IDLE one edge after d_ready returns to 1.
REQ-027 Back-to-back and abort:
- d_ready=0 during the LOAD cycle -> sel=1 in the next cycle, and the second frame completes with its own d_load pulse;
- rst_n pulsed during DATA -> sel drops immediately and no d_load occurs.
REQ-028 Parity compiled out (no RFSM_PARITY_EN): good frame -> d_load high between edges 9 and 10; toggling p_error has no effect on it.

Source files
------------

// File: rtl/rfsm.sv
// Serial frame receiver control FSM: start bit, WIDTH data bits, optional parity, stop bit.
// Define RFSM_PARITY_EN to include the PARITY state and parity-error word suppression.
module rfsm #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_ready,
    input  logic p_error,
    output logic sel,
    output logic d_load
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        LOAD   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          perr_q, perr_nx;
    logic          sel_nx, d_load_nx;

    // Outputs are registered from the next-state decode, so they stay Moore and glitch-free.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= 1'b0;
            d_load <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sel    <= sel_nx;
            d_load <= d_load_nx;
        end
    end

`ifdef RFSM_PARITY_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)
            perr_q <= 1'b0;
        else
            perr_q <= perr_nx;
    end
`else
    logic unused_perr;
    assign perr_q      = 1'b0;
    assign unused_perr = ^{perr_nx, p_error};
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        perr_nx  = perr_q;
        case (state)
            IDLE: begin
                if (!d_ready) begin
                    state_nx = DATA;
                    cnt_nx   = '0;
                    perr_nx  = 1'b0;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
`ifdef RFSM_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
`ifdef RFSM_PARITY_EN
            PARITY: begin
                perr_nx  = p_error;
                state_nx = STOP;
            end
`endif
            STOP: begin
                if (!d_ready)
                    state_nx = ERR;
                else if (perr_q)
                    state_nx = IDLE;
                else
                    state_nx = LOAD;
            end
            LOAD: begin
                if (!d_ready) begin
                    state_nx = DATA;
                    cnt_nx   = '0;
                    perr_nx  = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            ERR: begin
                if (d_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        sel_nx    = (state_nx == DATA);
        d_load_nx = (state_nx == LOAD);
    end

endmodule

// File: tb/tb_rfsm.sv
// Directed scoreboard bench for rfsm (WIDTH=8); expectations adapt to RFSM_PARITY_EN.
module tb_rfsm;

    localparam int WIDTH = 8;
`ifdef RFSM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, d_ready, p_error;
    logic sel, d_load;

    typedef struct {
        string tag;
        logic  s;
        logic  l;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rfsm #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_ready(d_ready),
        .p_error(p_error),
        .sel    (sel),
        .d_load (d_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs for the next edge, queue the outputs expected after it, then compare.
    task automatic step(input logic dr, input logic pe, input logic es, input logic el,
                        input string tag);
        exp_t e;
        @(negedge clk);
        d_ready = dr;
        p_error = pe;
        sb.push_back('{tag, es, el});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_sel"}, sel, e.s);
        chk({e.tag, "_load"}, d_load, e.l);
    endtask

    // Edges 1..WIDTH-1 of DATA, optional PARITY, then the STOP-closing edge.
    task automatic tail(input logic perr, input logic stop_bit, input string tag);
        for (int i = 1; i < WIDTH; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                 {tag, "_data"});
        step(1'b1, 1'b0, 1'b0, 1'b0, {tag, "_enter_tail"});
        if (PAR)
            step(1'b1, perr, 1'b0, 1'b0, {tag, "_parity"});
        if (!stop_bit)
            step(1'b0, 1'b0, 1'b0, 1'b0, {tag, "_stop_err"});
        else if (PAR && perr)
            step(1'b1, 1'b0, 1'b0, 1'b0, {tag, "_stop_perr"});
        else
            step(1'b1, 1'b0, 1'b0, 1'b1, {tag, "_stop_load"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        d_ready = 1'b1;
        p_error = 1'b0;
        rst_n   = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        chk("reset_sel", sel, 1'b0);
        chk("reset_load", d_load, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;

        // Idle with p_error toggling must not start anything.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'(i), 1'b0, 1'b0, "idle_hold");

        step(1'b0, 1'b1, 1'b1, 1'b0, "good_start");
        tail(1'b0, 1'b1, "good");
        step(1'b1, 1'b0, 1'b0, 1'b0, "good_idle");

        step(1'b0, 1'b0, 1'b1, 1'b0, "perr_start");
        tail(1'b1, 1'b1, "perr");
        step(1'b1, 1'b1, 1'b0, 1'b0, "perr_idle");

        step(1'b0, 1'b0, 1'b1, 1'b0, "ferr_start");
        tail(1'b0, 1'b0, "ferr");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "err_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, "err_exit");

        // First frame of a back-to-back pair also proves ERR released to IDLE in one edge.
        step(1'b0, 1'b0, 1'b1, 1'b0, "b2b1_start");
        tail(1'b0, 1'b1, "b2b1");
        step(1'b0, 1'b0, 1'b1, 1'b0, "b2b2_start");
        tail(1'b0, 1'b1, "b2b2");
        step(1'b1, 1'b0, 1'b0, 1'b0, "b2b_idle");

        step(1'b0, 1'b0, 1'b1, 1'b0, "abort_start");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, "abort_data");
        #3 rst_n = 1'b1;
        #1;
        chk("abort_sel", sel, 1'b0);
        chk("abort_load", d_load, 1'b0);
        @(posedge clk);
        #1;
        chk("abort_hold_sel", sel, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, "post_abort");

        step(1'b0, 1'b0, 1'b1, 1'b0, "final_start");
        tail(1'b0, 1'b1, "final");
        step(1'b1, 1'b0, 1'b0, 1'b0, "final_idle");

        chk("scoreboard_empty", 1'(sb.size() == 0), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
